redmule_mx_beat_packer: RTL and testbench

- Generalised MX output stage that follows the MX encoder.
- Accepts one encoded MX block per handshake: NUM_LANES elements plus one 8-bit shared exponent.
- Packs elements at a runtime-selectable element width (FP8/FP6/FP4) into dense DATAW_ALIGN-bit beats for the Z FIFO. Blocks may straddle beats.
- Groups shared exponents EXP_GROUP per beat on a separate stream.
- Handles end-of-tile flush with byte strobes.

---
 rtl/redmule_pkg.sv | 29 ++
 rtl/redmule_mx_lane_compactor.sv | 32 +++
 rtl/redmule_mx_beat_packer.sv | 207 ++++++++++++++++++++
 tb/tb_redmule_mx_beat_packer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// Shared MX definitions: element formats, format-to-width mapping and exponent width.
package redmule_pkg;

  localparam int unsigned MX_EXP_W = 8;

  typedef enum logic [1:0] {
    MX_FP8 = 2'd0,
    MX_FP6 = 2'd1,
    MX_FP4 = 2'd2
  } mx_fmt_e;

  // The reserved encoding 2'd3 behaves as FP8.
  function automatic mx_fmt_e mx_fmt_decode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MX_FP6;
      2'd2:    return MX_FP4;
      default: return MX_FP8;
    endcase
  endfunction

  function automatic int unsigned mx_fmt_width(input mx_fmt_e fmt);
    case (fmt)
      MX_FP6:  return 6;
      MX_FP4:  return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/redmule_mx_lane_compactor.sv
// Squeezes byte-spaced MX lanes down to the element width so lane k sits at bits [kW+W-1:kW].
module redmule_mx_lane_compactor
  import redmule_pkg::*;
#(
  parameter int unsigned NUM_LANES = 32
) (
  input  mx_fmt_e                    fmt_i,
  input  logic [NUM_LANES*8-1:0]     data_i,
  output logic [NUM_LANES*8-1:0]     data_o
);

  logic [NUM_LANES*8-1:0] fp8_data;
  logic [NUM_LANES*6-1:0] fp6_data;
  logic [NUM_LANES*4-1:0] fp4_data;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : gen_lane
    assign fp8_data[gi*8 +: 8] = data_i[gi*8 +: 8];
    assign fp6_data[gi*6 +: 6] = data_i[gi*8 +: 6];
    assign fp4_data[gi*4 +: 4] = data_i[gi*8 +: 4];
  end

  // Bits above the compacted block stay zero so the packer can OR blocks together.
  always_comb begin
    data_o = '0;
    case (fmt_i)
      MX_FP6:  data_o[NUM_LANES*6-1:0] = fp6_data;
      MX_FP4:  data_o[NUM_LANES*4-1:0] = fp4_data;
      default: data_o = fp8_data;
    endcase
  end

endmodule

// File: rtl/redmule_mx_beat_packer.sv
// MX output stage: packs compacted blocks into dense value beats and groups shared exponents.
module redmule_mx_beat_packer
  import redmule_pkg::*;
#(
  parameter int unsigned DATAW_ALIGN = 512,
  parameter int unsigned NUM_LANES   = 32,
  parameter int unsigned EXP_GROUP   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [1:0]                 fmt_i,
  input  logic                       blk_valid_i,
  output logic                       blk_ready_o,
  input  logic [NUM_LANES*8-1:0]     blk_data_i,
  input  logic [MX_EXP_W-1:0]        blk_exp_i,
  input  logic                       blk_last_i,
  output logic                       z_valid_o,
  input  logic                       z_ready_i,
  output logic [DATAW_ALIGN-1:0]     z_data_o,
  output logic [DATAW_ALIGN/8-1:0]   z_strb_o,
  output logic                       exp_valid_o,
  input  logic                       exp_ready_i,
  output logic [DATAW_ALIGN-1:0]     exp_data_o,
  output logic [DATAW_ALIGN/8-1:0]   exp_strb_o,
  output logic                       busy_o
);

  localparam int unsigned STRBW = DATAW_ALIGN / 8;
  localparam int unsigned CW    = $clog2(2 * DATAW_ALIGN);
  localparam int unsigned EW    = $clog2(EXP_GROUP + 1);
  localparam int unsigned EGW   = EXP_GROUP * MX_EXP_W;
  localparam int unsigned BLKW  = NUM_LANES * 8;

  localparam logic [CW-1:0] BEAT_BITS = CW'(DATAW_ALIGN);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  function automatic logic [STRBW-1:0] bytes_mask(input logic [CW-1:0] nbytes);
    logic [STRBW-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < STRBW; b++) m[b] = (CW'(b) < nbytes);
    return m;
  endfunction

  logic [0:0]             state_q;
  mx_fmt_e                fmt_q;
  logic [DATAW_ALIGN-1:0] acc_q;
  logic [CW-1:0]          fill_q;
  logic [EW-1:0]          ecnt_q;
  logic [EGW-1:0]         exp_buf_q;

  logic                   z_valid_q;
  logic [DATAW_ALIGN-1:0] z_data_q;
  logic [STRBW-1:0]       z_strb_q;
  logic                   exp_valid_q;
  logic [DATAW_ALIGN-1:0] exp_data_q;
  logic [STRBW-1:0]       exp_strb_q;

  logic                     tile_idle;
  mx_fmt_e                  fmt_eff;
  logic [CW-1:0]            blk_bits;
  logic [BLKW-1:0]          compact;
  logic [2*DATAW_ALIGN-1:0] compact_wide;
  logic [2*DATAW_ALIGN-1:0] combined;
  logic [CW-1:0]            sum;
  logic [CW-1:0]            resid;
  logic                     beat_full;
  logic                     z_need;
  logic                     z_free;
  logic [EW-1:0]            ecnt_inc;
  logic                     exp_full;
  logic                     exp_need;
  logic                     exp_free;
  logic                     accept;
  logic [EGW-1:0]           exp_buf_next;
  logic [DATAW_ALIGN-1:0]   exp_beat;

  // The format may only change at a tile boundary, where nothing is buffered.
  assign tile_idle = (fill_q == '0) && (ecnt_q == '0);
  assign fmt_eff   = tile_idle ? mx_fmt_decode(fmt_i) : fmt_q;
  assign blk_bits  = CW'(NUM_LANES * mx_fmt_width(fmt_eff));

  redmule_mx_lane_compactor #(
    .NUM_LANES (NUM_LANES)
  ) i_compactor (
    .fmt_i  (fmt_eff),
    .data_i (blk_data_i),
    .data_o (compact)
  );

  assign compact_wide = {{(2*DATAW_ALIGN-BLKW){1'b0}}, compact};
  assign combined     = {{DATAW_ALIGN{1'b0}}, acc_q} | (compact_wide << fill_q);
  assign sum          = fill_q + blk_bits;
  assign beat_full    = (sum >= BEAT_BITS);
  assign resid        = beat_full ? (sum - BEAT_BITS) : sum;

  assign ecnt_inc = ecnt_q + EW'(1);
  assign exp_full = (ecnt_inc == EW'(EXP_GROUP));

  // Every last block emits something on both streams, so it always needs both slots.
  assign z_need   = beat_full || blk_last_i;
  assign exp_need = exp_full || blk_last_i;
  assign z_free   = !z_valid_q || z_ready_i;
  assign exp_free = !exp_valid_q || exp_ready_i;

  assign blk_ready_o = (state_q == ST_RUN) && (!z_need || z_free) && (!exp_need || exp_free);
  assign accept      = blk_valid_i && blk_ready_o;

  for (genvar gi = 0; gi < EXP_GROUP; gi++) begin : gen_exp_slot
    assign exp_buf_next[gi*MX_EXP_W +: MX_EXP_W] =
      (ecnt_q == EW'(gi)) ? blk_exp_i : exp_buf_q[gi*MX_EXP_W +: MX_EXP_W];
  end

  always_comb begin
    exp_beat = '0;
    exp_beat[EGW-1:0] = exp_buf_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      fmt_q       <= MX_FP8;
      acc_q       <= '0;
      fill_q      <= '0;
      ecnt_q      <= '0;
      exp_buf_q   <= '0;
      z_valid_q   <= 1'b0;
      z_data_q    <= '0;
      z_strb_q    <= '0;
      exp_valid_q <= 1'b0;
      exp_data_q  <= '0;
      exp_strb_q  <= '0;
    end else if (clear_i) begin
      state_q     <= ST_RUN;
      fmt_q       <= MX_FP8;
      acc_q       <= '0;
      fill_q      <= '0;
      ecnt_q      <= '0;
      exp_buf_q   <= '0;
      z_valid_q   <= 1'b0;
      z_data_q    <= '0;
      z_strb_q    <= '0;
      exp_valid_q <= 1'b0;
      exp_data_q  <= '0;
      exp_strb_q  <= '0;
    end else begin
      if (z_valid_q && z_ready_i)     z_valid_q   <= 1'b0;
      if (exp_valid_q && exp_ready_i) exp_valid_q <= 1'b0;

      // Residual of a tile whose last block also completed a full beat.
      if (state_q == ST_FLUSH && z_free) begin
        z_data_q  <= acc_q;
        z_strb_q  <= bytes_mask((fill_q + CW'(7)) >> 3);
        z_valid_q <= 1'b1;
        acc_q     <= '0;
        fill_q    <= '0;
        state_q   <= ST_RUN;
      end

      if (accept) begin
        fmt_q <= fmt_eff;

        if (beat_full) begin
          z_data_q  <= combined[DATAW_ALIGN-1:0];
          z_strb_q  <= '1;
          z_valid_q <= 1'b1;
          acc_q     <= combined[2*DATAW_ALIGN-1:DATAW_ALIGN];
          fill_q    <= resid;
          if (blk_last_i && resid != '0) state_q <= ST_FLUSH;
        end else if (blk_last_i) begin
          z_data_q  <= combined[DATAW_ALIGN-1:0];
          z_strb_q  <= bytes_mask((sum + CW'(7)) >> 3);
          z_valid_q <= 1'b1;
          acc_q     <= '0;
          fill_q    <= '0;
        end else begin
          acc_q  <= combined[DATAW_ALIGN-1:0];
          fill_q <= sum;
        end

        if (exp_need) begin
          exp_data_q  <= exp_beat;
          exp_strb_q  <= bytes_mask(CW'(ecnt_inc));
          exp_valid_q <= 1'b1;
          exp_buf_q   <= '0;
          ecnt_q      <= '0;
        end else begin
          exp_buf_q <= exp_buf_next;
          ecnt_q    <= ecnt_inc;
        end
      end
    end
  end

  assign z_valid_o   = z_valid_q;
  assign z_data_o    = z_data_q;
  assign z_strb_o    = z_strb_q;
  assign exp_valid_o = exp_valid_q;
  assign exp_data_o  = exp_data_q;
  assign exp_strb_o  = exp_strb_q;

  assign busy_o = (fill_q != '0) || (ecnt_q != '0) || z_valid_q || exp_valid_q ||
                  (state_q == ST_FLUSH);

endmodule

// File: tb/tb_redmule_mx_beat_packer.sv
// Scoreboard bench: a bit-queue reference model predicts beats; a monitor checks each handshake.
module tb_redmule_mx_beat_packer;

  localparam int D  = 512;
  localparam int NL = 32;
  localparam int EG = 4;
  localparam int SB = D / 8;

  typedef struct {
    logic [D-1:0]  data;
    logic [SB-1:0] strb;
  } beat_t;

  logic            clk_i       = 1'b0;
  logic            rst_ni      = 1'b0;
  logic            clear_i     = 1'b0;
  logic [1:0]      fmt_i       = 2'd0;
  logic            blk_valid_i = 1'b0;
  logic            blk_ready_o;
  logic [NL*8-1:0] blk_data_i  = '0;
  logic [7:0]      blk_exp_i   = '0;
  logic            blk_last_i  = 1'b0;
  logic            z_valid_o;
  logic            z_ready_i   = 1'b1;
  logic [D-1:0]    z_data_o;
  logic [SB-1:0]   z_strb_o;
  logic            exp_valid_o;
  logic            exp_ready_i = 1'b1;
  logic [D-1:0]    exp_data_o;
  logic [SB-1:0]   exp_strb_o;
  logic            busy_o;

  int n_cmp = 0;
  int n_err = 0;

  logic rand_rdy = 1'b0;
  logic z_force  = 1'b1;
  logic e_force  = 1'b1;

  beat_t zq[$];
  beat_t eq_q[$];
  bit    bitq[$];
  logic [7:0] expbuf[$];
  int    tile_w = 8;
  beat_t zb, eb;

  redmule_mx_beat_packer #(
    .DATAW_ALIGN (D),
    .NUM_LANES   (NL),
    .EXP_GROUP   (EG)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .fmt_i       (fmt_i),
    .blk_valid_i (blk_valid_i),
    .blk_ready_o (blk_ready_o),
    .blk_data_i  (blk_data_i),
    .blk_exp_i   (blk_exp_i),
    .blk_last_i  (blk_last_i),
    .z_valid_o   (z_valid_o),
    .z_ready_i   (z_ready_i),
    .z_data_o    (z_data_o),
    .z_strb_o    (z_strb_o),
    .exp_valid_o (exp_valid_o),
    .exp_ready_i (exp_ready_i),
    .exp_data_o  (exp_data_o),
    .exp_strb_o  (exp_strb_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  always @(posedge clk_i) begin
    #1;
    if (rand_rdy) begin
      z_ready_i   = ($urandom_range(0, 3) != 0);
      exp_ready_i = ($urandom_range(0, 3) != 0);
    end else begin
      z_ready_i   = z_force;
      exp_ready_i = e_force;
    end
  end

  // Monitor: every handshake on either stream must match the head of its expected queue.
  always @(negedge clk_i) begin
    if (rst_ni && z_valid_o && z_ready_i) begin
      n_cmp++;
      if (zq.size() == 0) begin
        n_err++;
        $display("FAIL z_beat unexpected beat strb=%0h", z_strb_o);
      end else begin
        zb = zq.pop_front();
        if (z_data_o !== zb.data || z_strb_o !== zb.strb) begin
          n_err++;
          $display("FAIL z_beat got data=%0h strb=%0h want data=%0h strb=%0h",
                   z_data_o, z_strb_o, zb.data, zb.strb);
        end
      end
    end
    if (rst_ni && exp_valid_o && exp_ready_i) begin
      n_cmp++;
      if (eq_q.size() == 0) begin
        n_err++;
        $display("FAIL exp_beat unexpected beat strb=%0h", exp_strb_o);
      end else begin
        eb = eq_q.pop_front();
        if (exp_data_o !== eb.data || exp_strb_o !== eb.strb) begin
          n_err++;
          $display("FAIL exp_beat got data=%0h strb=%0h want data=%0h strb=%0h",
                   exp_data_o[63:0], exp_strb_o, eb.data[63:0], eb.strb);
        end
      end
    end
  end

  function automatic int fmt_w(input logic [1:0] f);
    case (f)
      2'd1:    return 6;
      2'd2:    return 4;
      default: return 8;
    endcase
  endfunction

  // Reference model: elements become a flat bit stream, cut into beats of D bits.
  task automatic model_accept(input logic [1:0] f, input logic [NL*8-1:0] d,
                              input logic [7:0] e, input logic last);
    beat_t b;
    int n;
    if (bitq.size() == 0 && expbuf.size() == 0) tile_w = fmt_w(f);
    for (int k = 0; k < NL; k++)
      for (int j = 0; j < tile_w; j++) bitq.push_back(d[k*8+j]);
    while (bitq.size() >= D) begin
      b.data = '0;
      for (int i = 0; i < D; i++) b.data[i] = bitq.pop_front();
      b.strb = '1;
      zq.push_back(b);
    end
    if (last && bitq.size() > 0) begin
      n = bitq.size();
      b.data = '0;
      b.strb = '0;
      for (int i = 0; i < n; i++) b.data[i] = bitq.pop_front();
      for (int i = 0; i < (n + 7) / 8; i++) b.strb[i] = 1'b1;
      zq.push_back(b);
    end
    expbuf.push_back(e);
    if (expbuf.size() == EG || last) begin
      b.data = '0;
      b.strb = '0;
      for (int i = 0; i < expbuf.size(); i++) begin
        b.data[i*8 +: 8] = expbuf[i];
        b.strb[i] = 1'b1;
      end
      eq_q.push_back(b);
      expbuf.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string nm, input logic [D-1:0] act, input logic [D-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] f, input logic [NL*8-1:0] d,
                       input logic [7:0] e, input logic last);
    blk_valid_i = 1'b1;
    fmt_i       = f;
    blk_data_i  = d;
    blk_exp_i   = e;
    blk_last_i  = last;
  endtask

  task automatic wait_accept();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_i);
      if (blk_ready_o) begin
        model_accept(fmt_i, blk_data_i, blk_exp_i, blk_last_i);
        @(posedge clk_i);
        #2;
        blk_valid_i = 1'b0;
        blk_last_i  = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL accept_timeout got=no_accept want=accept");
    blk_valid_i = 1'b0;
    blk_last_i  = 1'b0;
  endtask

  task automatic send(input logic [1:0] f, input logic [NL*8-1:0] d,
                      input logic [7:0] e, input logic last);
    drive(f, d, e, last);
    wait_accept();
  endtask

  task automatic drain();
    for (int c = 0; c < 2000; c++) begin
      if (zq.size() == 0 && eq_q.size() == 0 && !z_valid_o && !exp_valid_o) return;
      tick();
    end
    n_cmp++;
    n_err++;
    $display("FAIL drain_timeout got z_left=%0d exp_left=%0d want 0", zq.size(), eq_q.size());
  endtask

  function automatic logic [NL*8-1:0] rand_blk();
    logic [NL*8-1:0] d;
    for (int w = 0; w < NL * 8 / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  logic [NL*8-1:0] lane_idx;
  int len;
  logic [1:0] tf;

  initial begin
    for (int k = 0; k < NL; k++) lane_idx[k*8 +: 8] = 8'(k);

    // Reset
    repeat (3) @(negedge clk_i);
    chk("rst_z_valid", D'(z_valid_o), '0);
    chk("rst_exp_valid", D'(exp_valid_o), '0);
    chk("rst_z_data", z_data_o, '0);
    chk("rst_z_strb", D'(z_strb_o), '0);
    chk("rst_exp_data", exp_data_o, '0);
    chk("rst_busy", D'(busy_o), '0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", D'(blk_ready_o), D'(1));
    tick();

    // FP8: two blocks make one full beat, exponents grouped 2
    send(2'd0, lane_idx, 8'h11, 1'b0);
    send(2'd0, lane_idx, 8'h22, 1'b1);
    drain();

    // FP4: four blocks exactly fill one beat; busy falls after the handshakes
    for (int i = 0; i < 4; i++) send(2'd2, rand_blk(), 8'(8'h40 + i), (i == 3));
    @(negedge clk_i);
    chk("fp4_busy_pending", D'(busy_o), D'(1));
    @(negedge clk_i);
    chk("fp4_busy_idle", D'(busy_o), '0);
    drain();

    // FP6: 576 bits -> full beat then a flush beat; input stalls during FLUSH
    z_force = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) send(2'd1, rand_blk(), 8'(8'h60 + i), (i == 2));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("flush_ready", D'(blk_ready_o), '0);
    end
    z_force = 1'b1;
    drain();

    // Value backpressure: the block that would complete a second pending beat waits
    z_force = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) send(2'd0, rand_blk(), 8'(8'h80 + i), 1'b0);
    drive(2'd0, rand_blk(), 8'h83, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("bp_ready", D'(blk_ready_o), '0);
      chk("bp_z_hold", z_data_o, zq[0].data);
    end
    z_force = 1'b1;
    wait_accept();
    send(2'd0, rand_blk(), 8'h84, 1'b1);
    drain();

    // Exponent backpressure: 6 blocks -> strb 0xF then 0x3
    e_force = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) send(2'd0, rand_blk(), 8'(8'hA0 + i), 1'b0);
    drive(2'd0, rand_blk(), 8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("exp_bp_ready", D'(blk_ready_o), '0);
    end
    e_force = 1'b1;
    wait_accept();
    drain();

    // Mid-tile format change must be ignored
    send(2'd0, rand_blk(), 8'hC0, 1'b0);
    send(2'd2, rand_blk(), 8'hC1, 1'b1);
    drain();

    // Clear with pending beats, then a new tile latches FP4
    z_force = 1'b0;
    e_force = 1'b0;
    tick(); tick();
    send(2'd0, rand_blk(), 8'hD0, 1'b0);
    send(2'd0, rand_blk(), 8'hD1, 1'b0);
    tick();
    clear_i = 1'b1;
    zq.delete();
    eq_q.delete();
    bitq.delete();
    expbuf.delete();
    tick();
    clear_i = 1'b0;
    @(negedge clk_i);
    chk("clr_z_valid", D'(z_valid_o), '0);
    chk("clr_exp_valid", D'(exp_valid_o), '0);
    chk("clr_busy", D'(busy_o), '0);
    z_force = 1'b1;
    e_force = 1'b1;
    tick(); tick();
    send(2'd2, rand_blk(), 8'hE0, 1'b0);
    send(2'd2, rand_blk(), 8'hE1, 1'b1);
    drain();

    // Randomized tiles with random readies and occasional mid-tile fmt changes
    rand_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(1, 8);
      tf  = 2'($urandom_range(0, 3));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) tf = 2'($urandom_range(0, 3));
        send(tf, rand_blk(), 8'($urandom()), (b == len - 1));
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    rand_rdy = 1'b0;
    z_force  = 1'b1;
    e_force  = 1'b1;
    tick(); tick();
    drain();
    @(negedge clk_i);
    chk("end_busy", D'(busy_o), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
